// File: rtl/tlc_phase_arbiter.sv
// tlc_phase_arbiter
//   Multi-approach intersection scheduler. One approach is green at a time.
//   Vehicle sensor requests are latched and served round-robin. Each handover
//   runs GREEN -> YELLOW -> ALL_RED -> next GREEN, with min/max green timing.
//
// Optional feature macro: TLC_PED_PHASE_EN
//   When defined, ped_req latches a pedestrian request. That request inserts a
//   PED_WALK phase (all red, walk=1) after the ALL_RED clearance.
//   When undefined, ped_req is ignored and walk is tied low.
//
// Ports
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   sensor     in   [NUM_APPR] per-approach vehicle presence (level)
//   ped_req    in   pedestrian button (level)
//   lights     out  [2*NUM_APPR] per-approach code at [2i+1:2i]: 00 red, 01 green, 10 yellow
//   grant      out  [NUM_APPR] one-hot green/yellow owner, zero in ALL_RED/PED_WALK
//   phase_idx  out  index of the current (or last) owner
//   walk       out  pedestrian walk indication
//   phase_done out  one-cycle pulse on the cycle a new GREEN is entered
module tlc_phase_arbiter #(
    parameter int NUM_APPR  = 4,
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW_T  = 4,
    parameter int ALL_RED_T = 2,
    parameter int PED_T     = 6
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_APPR-1:0]         sensor,
    input  logic                        ped_req,
    output logic [2*NUM_APPR-1:0]       lights,
    output logic [NUM_APPR-1:0]         grant,
    output logic [$clog2(NUM_APPR)-1:0] phase_idx,
    output logic                        walk,
    output logic                        phase_done
);

    localparam int OW = $clog2(NUM_APPR);

    // The timer must hold the longest terminal count of any state.
    localparam int T_A  = (MAX_GREEN > PED_T) ? MAX_GREEN : PED_T;
    localparam int T_B  = (YELLOW_T > ALL_RED_T) ? YELLOW_T : ALL_RED_T;
    localparam int TMAX = (T_A > T_B) ? T_A : T_B;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] MING_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAXG_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(ALL_RED_T - 1);
    localparam logic [TW-1:0] T_SAT     = '1;

    localparam logic [1:0] ST_GREEN   = 2'd0;
    localparam logic [1:0] ST_YELLOW  = 2'd1;
    localparam logic [1:0] ST_ALL_RED = 2'd2;
`ifdef TLC_PED_PHASE_EN
    localparam logic [1:0] ST_PED     = 2'd3;
    localparam logic [TW-1:0] PED_LAST = TW'(PED_T - 1);
`endif

    logic [1:0]          state, state_nxt;
    logic [OW-1:0]       owner, owner_nxt;
    logic [TW-1:0]       timer;
    logic [NUM_APPR-1:0] pending;
    logic                enter;        // any state entry: clears the timer
    logic                enter_green;  // entry into GREEN: clears pending[owner_nxt]
    logic [NUM_APPR-1:0] owner_oh;
    logic [NUM_APPR-1:0] set_mask;
    logic [NUM_APPR-1:0] clr_mask;
    logic                other_pending;
    logic                phase_done_q;

`ifdef TLC_PED_PHASE_EN
    logic ped_pending;
    logic ped_clr;
`else
    logic unused_ped;
    assign unused_ped = ped_req;
`endif

    // Round-robin search starting after cur; the owner itself is checked
    // last. Returns fallback when nothing is requested.
    function automatic logic [OW-1:0] rr_next(input logic [NUM_APPR-1:0] req,
                                              input logic [OW-1:0]       cur,
                                              input logic [OW-1:0]       fallback);
        logic          found;
        logic [OW-1:0] idx;
        rr_next = fallback;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NUM_APPR; k++) begin
            idx = OW'((32'(cur) + k) % NUM_APPR);
            if (!found && req[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign owner_oh = NUM_APPR'(1) << owner;

`ifdef TLC_PED_PHASE_EN
    assign other_pending = (|(pending & ~owner_oh)) | ped_pending;
`else
    assign other_pending = |(pending & ~owner_oh);
`endif

    // The owner's own sensor does not latch while it holds green; it is
    // the extension input instead.
    assign set_mask = sensor & ~((state == ST_GREEN) ? owner_oh : '0);
    assign clr_mask = enter_green ? (NUM_APPR'(1) << owner_nxt) : '0;

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        enter       = 1'b0;
        enter_green = 1'b0;
`ifdef TLC_PED_PHASE_EN
        ped_clr     = 1'b0;
`endif
        case (state)
            ST_GREEN: begin
                if (timer >= MING_LAST && other_pending &&
                    (!sensor[owner] || timer >= MAXG_LAST)) begin
                    state_nxt = ST_YELLOW;
                    enter     = 1'b1;
                end
            end
            ST_YELLOW: begin
                if (timer == YEL_LAST) begin
                    state_nxt = ST_ALL_RED;
                    enter     = 1'b1;
                end
            end
            ST_ALL_RED: begin
                if (timer == AR_LAST) begin
                    enter = 1'b1;
`ifdef TLC_PED_PHASE_EN
                    if (ped_pending) begin
                        state_nxt = ST_PED;
                        ped_clr   = 1'b1;
                    end else begin
                        state_nxt   = ST_GREEN;
                        owner_nxt   = rr_next(pending, owner, '0);
                        enter_green = 1'b1;
                    end
`else
                    state_nxt   = ST_GREEN;
                    owner_nxt   = rr_next(pending, owner, '0);
                    enter_green = 1'b1;
`endif
                end
            end
`ifdef TLC_PED_PHASE_EN
            ST_PED: begin
                if (timer == PED_LAST) begin
                    state_nxt   = ST_GREEN;
                    owner_nxt   = rr_next(pending, owner, owner);
                    enter       = 1'b1;
                    enter_green = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = ST_GREEN;
                owner_nxt = '0;
                enter     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_GREEN;
            owner        <= '0;
            timer        <= '0;
            pending      <= '0;
            phase_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            owner        <= owner_nxt;
            // Saturation only matters while resting on green.
            timer        <= enter ? '0 : ((timer == T_SAT) ? timer : timer + 1'b1);
            // Clear wins over a same-cycle set.
            pending      <= (pending | set_mask) & ~clr_mask;
            phase_done_q <= enter_green;
        end
    end

`ifdef TLC_PED_PHASE_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ped_pending <= 1'b0;
        end else begin
            ped_pending <= (ped_pending | ped_req) & ~ped_clr;
        end
    end
`endif

    always_comb begin
        lights = '0;
        grant  = '0;
        for (int unsigned i = 0; i < NUM_APPR; i++) begin
            if (owner_oh[i]) begin
                if (state == ST_GREEN) begin
                    lights[2*i +: 2] = 2'b01;
                    grant[i]         = 1'b1;
                end else if (state == ST_YELLOW) begin
                    lights[2*i +: 2] = 2'b10;
                    grant[i]         = 1'b1;
                end
            end
        end
    end

    assign phase_idx  = owner;
    assign phase_done = phase_done_q;
`ifdef TLC_PED_PHASE_EN
    assign walk = (state == ST_PED);
`else
    assign walk = 1'b0;
`endif

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// tb_tlc_phase_arbiter
//   Directed self-checking bench for tlc_phase_arbiter with default parameters.
//   Cycle k means the state after k rising edges following reset release.
//   Inputs are driven 1 time unit after an edge. Outputs are checked there too.
module tb_tlc_phase_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] sensor;
    logic       ped_req;
    logic [7:0] lights;
    logic [3:0] grant;
    logic [1:0] phase_idx;
    logic       walk;
    logic       phase_done;

    int tests = 0;
    int fails = 0;

    tlc_phase_arbiter #(
        .NUM_APPR (4),
        .MIN_GREEN(10),
        .MAX_GREEN(20),
        .YELLOW_T (4),
        .ALL_RED_T(2),
        .PED_T    (6)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sensor    (sensor),
        .ped_req   (ped_req),
        .lights    (lights),
        .grant     (grant),
        .phase_idx (phase_idx),
        .walk      (walk),
        .phase_done(phase_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] s, input logic p);
        sensor  = s;
        ped_req = p;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        sensor  = '0;
        ped_req = 1'b0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_l;
        int         pd_cnt;
        int         bad_l;
        logic       saw_g2;

        // Reset values
        sensor  = '0;
        ped_req = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("rst_lights", 32'(lights), 32'h01);
        chk("rst_grant", 32'(grant), 32'h1);
        chk("rst_idx", 32'(phase_idx), 32'h0);
        chk("rst_walk", 32'(walk), 32'h0);
        chk("rst_pdone", 32'(phase_done), 32'h0);

        // Rest on green: no requests for 200 cycles
        do_reset();
        pd_cnt = 0;
        bad_l  = 0;
        for (int c = 0; c < 200; c++) begin
            if (phase_done) pd_cnt++;
            if (lights !== 8'h01) bad_l++;
            step(4'b0000, 1'b0);
        end
        chk("rest_pdone_cnt", 32'(pd_cnt), 32'h0);
        chk("rest_bad_lights", 32'(bad_l), 32'h0);
        chk("rest_grant", 32'(grant), 32'h1);

        // sensor[2] pulsed at cycle 3: min green then handover to 2 at cycle 16
        do_reset();
        for (int c = 0; c <= 17; c++) begin
            exp_l = (c <= 9) ? 8'h01 : (c <= 13) ? 8'h02 : (c <= 15) ? 8'h00 : 8'h10;
            chk($sformatf("hand_lights_c%0d", c), 32'(lights), 32'(exp_l));
            chk($sformatf("hand_pdone_c%0d", c), 32'(phase_done), (c == 16) ? 32'h1 : 32'h0);
            if (c == 16) begin
                chk("hand_pend2", 32'(dut.pending[2]), 32'h0);
                chk("hand_grant", 32'(grant), 32'h4);
                chk("hand_idx", 32'(phase_idx), 32'h2);
            end
            step((c == 3) ? 4'b0100 : 4'b0000, 1'b0);
        end

        // Owner's own sensor extends green to MAX_GREEN
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            if (c == 19) chk("maxg_last_green", 32'(lights), 32'h01);
            if (c == 20) chk("maxg_yellow", 32'(lights), 32'h02);
            step((c == 0) ? 4'b0011 : 4'b0001, 1'b0);
        end

        // Without extension green lasts MIN_GREEN
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            if (c == 9)  chk("ming_last_green", 32'(lights), 32'h01);
            if (c == 10) chk("ming_yellow", 32'(lights), 32'h02);
            if (c == 16) chk("ming_next_green", 32'(lights), 32'h04);
            step((c == 0) ? 4'b0010 : 4'b0000, 1'b0);
        end

        // Owner 1 with requests 0 and 3 together: 3 first, then 0
        do_reset();
        for (int c = 0; c <= 49; c++) begin
            if (c == 16) begin
                chk("rr_own1_idx", 32'(phase_idx), 32'h1);
                chk("rr_own1_lights", 32'(lights), 32'h04);
            end
            if (c == 25) chk("rr_own1_last", 32'(lights), 32'h04);
            if (c == 26) chk("rr_own1_yellow", 32'(lights), 32'h08);
            if (c == 32) begin
                chk("rr_to3_idx", 32'(phase_idx), 32'h3);
                chk("rr_to3_lights", 32'(lights), 32'h40);
                chk("rr_to3_pend", 32'(dut.pending), 32'h1);
                chk("rr_to3_pdone", 32'(phase_done), 32'h1);
            end
            if (c == 48) begin
                chk("rr_to0_idx", 32'(phase_idx), 32'h0);
                chk("rr_to0_lights", 32'(lights), 32'h01);
                chk("rr_to0_pdone", 32'(phase_done), 32'h1);
            end
            step((c == 0) ? 4'b0010 : (c == 16) ? 4'b1001 : 4'b0000, 1'b0);
        end
        chk("rr_rest0_grant", 32'(grant), 32'h1);

        // Reset asserted during approach 2 yellow
        do_reset();
        for (int c = 0; c <= 27; c++) begin
            step((c == 3) ? 4'b0100 : (c == 16) ? 4'b0010 : 4'b0000, 1'b0);
        end
        chk("mid_yel2_lights", 32'(lights), 32'h20);
        chk("mid_yel2_grant", 32'(grant), 32'h4);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_lights", 32'(lights), 32'h01);
        chk("mid_rst_grant", 32'(grant), 32'h1);
        chk("mid_rst_pend", 32'(dut.pending), 32'h0);
        chk("mid_rst_idx", 32'(phase_idx), 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        saw_g2  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (grant === 4'b0100) saw_g2 = 1'b1;
            step(4'b0000, 1'b0);
        end
        chk("mid_no_g2", 32'(saw_g2), 32'h0);
        chk("mid_after_lights", 32'(lights), 32'h01);

        // Pedestrian request
        do_reset();
`ifdef TLC_PED_PHASE_EN
        for (int c = 0; c <= 23; c++) begin
            exp_l = (c <= 9) ? 8'h01 : (c <= 13) ? 8'h02 : (c <= 21) ? 8'h00 : 8'h01;
            chk($sformatf("ped_lights_c%0d", c), 32'(lights), 32'(exp_l));
            chk($sformatf("ped_walk_c%0d", c), 32'(walk), (c >= 16 && c <= 21) ? 32'h1 : 32'h0);
            if (c == 18) chk("ped_grant", 32'(grant), 32'h0);
            if (c == 22) chk("ped_pdone", 32'(phase_done), 32'h1);
            step(4'b0000, (c == 2));
        end
`else
        for (int c = 0; c < 30; c++) begin
            chk($sformatf("noped_walk_c%0d", c), 32'(walk), 32'h0);
            chk($sformatf("noped_lights_c%0d", c), 32'(lights), 32'h01);
            step(4'b0000, (c == 2));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tlc_phase_arbiter.md
Name: tlc_phase_arbiter

Overview:
- Multi-approach intersection scheduler: arbitrates green time among NUM_APPR approaches, one approach green at a time.
- Latches vehicle sensor requests and grants in round-robin order.
- Sequences each handover GREEN -> YELLOW -> ALL_RED -> next GREEN, with min/max green timing.
- Drives per-approach light codes for the intersection light drivers.

Parameters:
- NUM_APPR, 4, number of approaches (2..8).
- MIN_GREEN, 10, minimum green cycles per grant (>=1).
- MAX_GREEN, 20, maximum green cycles when the green approach's own sensor extends it (>=MIN_GREEN).
- YELLOW_T, 4, yellow cycles (>=1).
- ALL_RED_T, 2, all-red clearance cycles (>=1).
- PED_T, 6, pedestrian walk cycles (>=1); used only with TLC_PED_PHASE_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sensor  in  NUM_APPR  per-approach vehicle presence, level, synchronous to clock.
- ped_req  in  1  pedestrian button, level; ignored without TLC_PED_PHASE_EN.
- lights  out  2*NUM_APPR  per-approach code at [2i+1:2i]; 00 red, 01 green, 10 yellow, 11 never driven.
- grant  out  NUM_APPR  one-hot, current green/yellow owner; all zero in ALL_RED/PED_WALK.
- phase_idx  out  $clog2(NUM_APPR)  index of current owner (last owner during ALL_RED).
- walk  out  1  pedestrian walk indication.
- phase_done  out  1  one-cycle pulse on the cycle a new GREEN is entered.

Behaviour:
- Interface: one clock, `clock`. Reset is asynchronous and active-low on `reset_n`.
- Reset values:
  - state GREEN, owner 0, timer 0, pending 0, ped_pending 0.
  - lights: approach 0 = 01, all others = 00.
  - grant = 1 (one-hot bit 0); phase_idx = 0; walk = 0; phase_done = 0.
- Registered outputs: outputs are a combinational decode of registered state only; no input-to-output paths.
- Timer:
  - Cleared on every state entry; increments each cycle in the state.
  - A state of length T exits on the cycle timer == T-1, so the state is held exactly T cycles.
  - Width covers max(MAX_GREEN, PED_T) without wrap; the timer saturates in GREEN rest.
- Request latch:
  - pending[i] is set on any cycle sensor[i]=1, except for the current owner while it is in GREEN.
  - pending[i] is cleared on the cycle approach i enters GREEN.
  - If set and clear coincide, clear wins.
- States:
  - GREEN: the owner's code is 01, all others 00.
    - Exit to YELLOW when timer >= MIN_GREEN-1 AND any other pending bit is set AND (sensor[owner]=0 OR timer >= MAX_GREEN-1).
    - With no other pending bit, remain in GREEN indefinitely (rest on green).
  - YELLOW: the owner's code is 10. Exit to ALL_RED after YELLOW_T cycles.
  - ALL_RED: all codes 00. After ALL_RED_T cycles, the new owner is the first set pending bit searching owner+1, owner+2, ... modulo NUM_APPR (round-robin).
    - pending is sampled on the exit cycle itself.
    - If no bit is set (defensive only), the new owner is 0.
    - Enter GREEN and pulse phase_done.
  - PED_WALK: present only with the feature; see Optional Feature.
- Simultaneous requests: resolved only by round-robin order from the current owner; there is no fixed priority.
- Reset mid-operation: asserting reset_n=0 in any state immediately forces the reset values; no yellow is shown on reset.
- Invalid state encoding: recover to GREEN, owner 0.

Optional Feature:
- Macro: TLC_PED_PHASE_EN.
- Defined:
  - ped_req=1 sets ped_pending.
  - In GREEN, ped_pending counts as an "other pending" request for the exit condition.
  - At ALL_RED exit, if ped_pending=1, enter PED_WALK instead of the next GREEN.
  - PED_WALK: all lights 00, walk=1, grant=0, for PED_T cycles. Clear ped_pending on entry.
  - After PED_WALK, perform normal round-robin selection from the last owner. If no vehicle bit is pending, return to the last owner.
- Not defined:
  - ped_req is ignored, walk is tied 0, and the PED_WALK state does not exist.
  - Port list is unchanged.

Test Plan:
- Reset released, sensor=0 for 200 cycles -> lights=8'b00000001, grant=4'b0001, phase_done never pulses.
- Defaults; sensor[2] pulsed 1 cycle at cycle 3 after reset -> approach 0 green for cycles 0-9, yellow cycles 10-13, all red cycles 14-15; approach 2 green at cycle 16 with phase_done=1 and pending[2]=0.
- Owner 0 with sensor[0] held high, sensor[1] pulsed at cycle 0 -> green lasts exactly 20 cycles (MAX_GREEN). With sensor[0] low -> exactly 10 cycles.
- Owner 1, pending bits 0 and 3 set together -> next green is 3, then 0; never 1 twice in a row.
- reset_n pulsed low during YELLOW of approach 2 -> same cycle lights=8'b00000001 and pending cleared; approach 2 is not granted afterwards unless re-requested.
- With TLC_PED_PHASE_EN: ped_req pulsed during approach 0 green, no vehicle requests -> yellow 4, all red 2, walk=1 for 6 cycles with all lights red, then approach 0 green again. Without the macro: ped_req ignored, walk stays 0.
